// File: rtl/mode_sel_pkg.sv
// mode_sel_pkg: shared encodings for the mode selector.
//   ms_state_e : press-tracking FSM states (IDLE / HELD / LONG)
//   DIR_UP / DIR_DOWN : values of the dir input
package mode_sel_pkg;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_HELD = 2'd1,
        MS_LONG = 2'd2
    } ms_state_e;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/mode_select_fsm_hold_timer.sv
// hold_timer: saturating press-duration counter for the long-press detector.
//   clk, rst : clock, async active-high reset
//   clr      : clear count to 0 (wins over en)
//   en       : count one more high sample, saturating at HOLD_TICKS
//   reached  : high when the sample counted on this edge is the HOLD_TICKS-th
//              (combinational, so the caller acts on the same edge)
module hold_timer #(
    parameter int unsigned HOLD_TICKS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic reached
);

    localparam int unsigned CNT_W = $clog2(HOLD_TICKS + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_W'(HOLD_TICKS))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign reached = en && !clr && (cnt_q == CNT_W'(HOLD_TICKS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mode_select_fsm.sv
// mode_select_fsm: N-mode selector stepped by a debounced button.
//   clk_100hz    : system tick clock
//   rst          : async active-high reset
//   press_level  : debounced button level
//   dir          : step direction (DIR_UP = +1, DIR_DOWN = -1)
//   lock         : ignore presses and drop any press in progress
//   mode         : registered mode index
//   mode_changed : one-cycle pulse per step or long-press load
//   wrapped      : one-cycle pulse when a step wraps around
// Build option: define MODE_SEL_LONG_PRESS_EN to commit steps on release and
// load DEFAULT_MODE after HOLD_TICKS high samples; otherwise steps commit on press.
module mode_select_fsm
    import mode_sel_pkg::*;
#(
    parameter int unsigned NUM_MODES    = 2,
    parameter int unsigned MODE_W       = 1,
    parameter int unsigned DEFAULT_MODE = 0,
    parameter int unsigned HOLD_TICKS   = 200
) (
    input  logic              clk_100hz,
    input  logic              rst,
    input  logic              press_level,
    input  logic              dir,
    input  logic              lock,
    output logic [MODE_W-1:0] mode,
    output logic              mode_changed,
    output logic              wrapped
);

    // Elaboration-time parameter sanity checks.
    if (NUM_MODES < 2 || NUM_MODES > 16) begin : g_bad_num_modes
        $error("NUM_MODES out of range 2..16");
    end
    if (MODE_W != (($clog2(NUM_MODES) < 1) ? 1 : $clog2(NUM_MODES))) begin : g_bad_mode_w
        $error("MODE_W must equal clog2(NUM_MODES)");
    end
    if (DEFAULT_MODE >= NUM_MODES) begin : g_bad_default
        $error("DEFAULT_MODE must be below NUM_MODES");
    end
    if (HOLD_TICKS < 2 || HOLD_TICKS > 4095) begin : g_bad_hold
        $error("HOLD_TICKS out of range 2..4095");
    end

    localparam int unsigned EXT_W = MODE_W + 1;

    logic              prev_q, prev_d;
    logic [MODE_W-1:0] mode_q, mode_d;
    logic              mode_changed_q, mode_changed_d;
    logic              wrapped_q, wrapped_d;

    logic              rise;
    logic              commit;
    logic [EXT_W-1:0]  mode_ext;
    logic [EXT_W-1:0]  step_ext;
    logic              step_wrap;

    assign rise     = press_level & ~prev_q;
    assign mode_ext = {1'b0, mode_q};

    // Candidate next mode for a step, wrapping by explicit compare.
    always_comb begin
        step_ext  = mode_ext;
        step_wrap = 1'b0;
        case (dir)
            DIR_UP: begin
                if (mode_ext == EXT_W'(NUM_MODES - 1)) begin
                    step_ext  = '0;
                    step_wrap = 1'b1;
                end else begin
                    step_ext = mode_ext + EXT_W'(1);
                end
            end
            DIR_DOWN: begin
                if (mode_ext == '0) begin
                    step_ext  = EXT_W'(NUM_MODES - 1);
                    step_wrap = 1'b1;
                end else begin
                    step_ext = mode_ext - EXT_W'(1);
                end
            end
        endcase
    end

`ifdef MODE_SEL_LONG_PRESS_EN
    ms_state_e state_q, state_d;
    logic      fall;
    logic      tmr_clr;
    logic      tmr_en;
    logic      tmr_reached;

    assign fall = ~press_level & prev_q;

    hold_timer #(
        .HOLD_TICKS(HOLD_TICKS)
    ) u_hold_timer (
        .clk     (clk_100hz),
        .rst     (rst),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .reached (tmr_reached)
    );
`endif

    // Next-state and output logic.
    always_comb begin
        prev_d         = press_level;
        mode_d         = mode_q;
        mode_changed_d = 1'b0;
        wrapped_d      = 1'b0;
        commit         = 1'b0;
`ifdef MODE_SEL_LONG_PRESS_EN
        state_d = state_q;
        tmr_clr = 1'b0;
        tmr_en  = 1'b0;
        if (lock) begin
            state_d = MS_IDLE;
            tmr_clr = 1'b1;
        end else begin
            case (state_q)
                MS_IDLE: begin
                    if (rise) begin
                        state_d = MS_HELD;
                        tmr_en  = 1'b1;
                    end
                end
                MS_HELD: begin
                    if (press_level) begin
                        tmr_en = 1'b1;
                        if (tmr_reached) begin
                            mode_d         = MODE_W'(DEFAULT_MODE);
                            mode_changed_d = 1'b1;
                            state_d        = MS_LONG;
                        end
                    end else begin
                        // Released before the hold threshold: short press.
                        commit  = 1'b1;
                        state_d = MS_IDLE;
                        tmr_clr = 1'b1;
                    end
                end
                MS_LONG: begin
                    if (fall) begin
                        state_d = MS_IDLE;
                        tmr_clr = 1'b1;
                    end
                end
                default: begin
                    state_d = MS_IDLE;
                    tmr_clr = 1'b1;
                end
            endcase
        end
`else
        commit = rise & ~lock;
`endif
        if (commit) begin
            mode_d         = step_ext[MODE_W-1:0];
            mode_changed_d = 1'b1;
            wrapped_d      = step_wrap;
        end
    end

    // prev resets high so a level still held at reset release is not a rise;
    // it drops only once the button is sampled low.
    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            prev_q         <= 1'b1;
            mode_q         <= MODE_W'(DEFAULT_MODE);
            mode_changed_q <= 1'b0;
            wrapped_q      <= 1'b0;
`ifdef MODE_SEL_LONG_PRESS_EN
            state_q        <= MS_IDLE;
`endif
        end else begin
            prev_q         <= prev_d;
            mode_q         <= mode_d;
            mode_changed_q <= mode_changed_d;
            wrapped_q      <= wrapped_d;
`ifdef MODE_SEL_LONG_PRESS_EN
            state_q        <= state_d;
`endif
        end
    end

    assign mode         = mode_q;
    assign mode_changed = mode_changed_q;
    assign wrapped      = wrapped_q;

endmodule

// File: tb/tb_mode_select_fsm.sv
// tb_mode_select_fsm: directed bench for mode_select_fsm with NUM_MODES=3,
// DEFAULT_MODE=0, HOLD_TICKS=4. Exercises whichever build option
// (MODE_SEL_LONG_PRESS_EN) the design is compiled with.
module tb_mode_select_fsm;

    logic       clk_100hz;
    logic       rst;
    logic       press_level;
    logic       dir;
    logic       lock;
    logic [1:0] mode;
    logic       mode_changed;
    logic       wrapped;

    int unsigned n_checks;
    int unsigned n_fail;
    int unsigned step_no;

    mode_select_fsm #(
        .NUM_MODES    (3),
        .MODE_W       (2),
        .DEFAULT_MODE (0),
        .HOLD_TICKS   (4)
    ) dut (
        .clk_100hz    (clk_100hz),
        .rst          (rst),
        .press_level  (press_level),
        .dir          (dir),
        .lock         (lock),
        .mode         (mode),
        .mode_changed (mode_changed),
        .wrapped      (wrapped)
    );

    initial clk_100hz = 1'b0;
    always #5 clk_100hz = ~clk_100hz;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Check all three outputs against hand-computed values.
    task automatic expect_out(input string tag, input int unsigned m, input int unsigned c,
                              input int unsigned w);
        step_no++;
        check($sformatf("%s#%0d.mode", tag, step_no), 32'(mode), m);
        check($sformatf("%s#%0d.changed", tag, step_no), 32'(mode_changed), c);
        check($sformatf("%s#%0d.wrapped", tag, step_no), 32'(wrapped), w);
    endtask

    // Drive the button level for one clock, then sample just after the edge.
    task automatic cyc(input logic lvl);
        press_level = lvl;
        @(posedge clk_100hz);
        #1;
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        step_no     = 0;
        rst         = 1'b1;
        press_level = 1'b0;
        dir         = 1'b0;
        lock        = 1'b0;

        // Reset held for three cycles.
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0);
            expect_out("reset", 0, 0, 0);
        end
        rst = 1'b0;
        cyc(1'b0);
        expect_out("rst_rel", 0, 0, 0);

`ifndef MODE_SEL_LONG_PRESS_EN
        // Up-wrap: 1, 2, 0; wrapped only on the third press.
        dir = 1'b0;
        cyc(1'b1); expect_out("up1", 1, 1, 0);
        cyc(1'b0); expect_out("up1r", 1, 0, 0);
        cyc(1'b1); expect_out("up2", 2, 1, 0);
        cyc(1'b0); expect_out("up2r", 2, 0, 0);
        cyc(1'b1); expect_out("up3", 0, 1, 1);
        cyc(1'b0); expect_out("up3r", 0, 0, 0);

        // Down-wrap from 0.
        dir = 1'b1;
        cyc(1'b1); expect_out("dn_wrap", 2, 1, 1);
        cyc(1'b0); expect_out("dn_wrapr", 2, 0, 0);

        // Back-to-back presses with no dead time.
        dir = 1'b0;
        cyc(1'b1); expect_out("b2b1", 0, 1, 1);
        cyc(1'b0); expect_out("b2b1r", 0, 0, 0);
        cyc(1'b1); expect_out("b2b2", 1, 1, 0);
        cyc(1'b0); expect_out("b2b2r", 1, 0, 0);
        dir = 1'b1;
        cyc(1'b1); expect_out("dn_plain", 0, 1, 0);
        cyc(1'b0); expect_out("dn_plainr", 0, 0, 0);

        // Lock suppresses the press; a level held through unlock is not a rise.
        lock = 1'b1;
        cyc(1'b1); expect_out("lock1", 0, 0, 0);
        cyc(1'b1); expect_out("lock2", 0, 0, 0);
        lock = 1'b0;
        cyc(1'b1); expect_out("unlock_held", 0, 0, 0);
        cyc(1'b0); expect_out("unlock_rel", 0, 0, 0);
        cyc(1'b1); expect_out("post_lock", 2, 1, 1);
        cyc(1'b0); expect_out("post_lockr", 2, 0, 0);

        // Async reset mid-press with the level still high afterwards.
        dir = 1'b0;
        cyc(1'b1); expect_out("pre_rst1", 0, 1, 1);
        cyc(1'b0); expect_out("pre_rst1r", 0, 0, 0);
        cyc(1'b1); expect_out("pre_rst2", 1, 1, 0);
`else
        // Short presses commit on release.
        dir = 1'b0;
        cyc(1'b1); expect_out("sp_h1", 0, 0, 0);
        cyc(1'b1); expect_out("sp_h2", 0, 0, 0);
        cyc(1'b1); expect_out("sp_h3", 0, 0, 0);
        cyc(1'b0); expect_out("sp_rel", 1, 1, 0);
        cyc(1'b1); expect_out("sp2_h", 1, 0, 0);
        cyc(1'b0); expect_out("sp2_rel", 2, 1, 0);

        // Long press from 2: load default on 4th high edge, no step on release.
        cyc(1'b1); expect_out("lp_h1", 2, 0, 0);
        cyc(1'b1); expect_out("lp_h2", 2, 0, 0);
        cyc(1'b1); expect_out("lp_h3", 2, 0, 0);
        cyc(1'b1); expect_out("lp_h4", 0, 1, 0);
        cyc(1'b1); expect_out("lp_h5", 0, 0, 0);
        cyc(1'b1); expect_out("lp_h6", 0, 0, 0);
        cyc(1'b0); expect_out("lp_rel", 0, 0, 0);

        // Long press while already at default still pulses mode_changed.
        cyc(1'b1); expect_out("lpd_h1", 0, 0, 0);
        cyc(1'b1); expect_out("lpd_h2", 0, 0, 0);
        cyc(1'b1); expect_out("lpd_h3", 0, 0, 0);
        cyc(1'b1); expect_out("lpd_h4", 0, 1, 0);
        cyc(1'b0); expect_out("lpd_rel", 0, 0, 0);

        // One-cycle press down from 0 wraps to 2.
        dir = 1'b1;
        cyc(1'b1); expect_out("dn_h", 0, 0, 0);
        cyc(1'b0); expect_out("dn_rel", 2, 1, 1);
        cyc(1'b0); expect_out("dn_idle", 2, 0, 0);

        // Lock mid-hold discards the press.
        dir = 1'b0;
        cyc(1'b1); expect_out("lk_h0", 2, 0, 0);
        lock = 1'b1;
        cyc(1'b1); expect_out("lk_h1", 2, 0, 0);
        cyc(1'b1); expect_out("lk_h2", 2, 0, 0);
        cyc(1'b1); expect_out("lk_h3", 2, 0, 0);
        lock = 1'b0;
        cyc(1'b1); expect_out("lk_held", 2, 0, 0);
        cyc(1'b0); expect_out("lk_rel", 2, 0, 0);

        // Get to a non-default mode, then hold before the reset.
        cyc(1'b1); expect_out("pr_h1", 2, 0, 0);
        cyc(1'b0); expect_out("pr_r1", 0, 1, 1);
        cyc(1'b1); expect_out("pr_h2", 0, 0, 0);
        cyc(1'b0); expect_out("pr_r2", 1, 1, 0);
        cyc(1'b1); expect_out("pr_h3", 1, 0, 0);
        cyc(1'b1); expect_out("pr_h4", 1, 0, 0);
`endif

        // Async reset mid-cycle: outputs clear before any clock edge.
        #2 rst = 1'b1;
        #1;
        check("async_rst.mode", 32'(mode), 0);
        check("async_rst.changed", 32'(mode_changed), 0);
        @(posedge clk_100hz);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(1'b1);
            expect_out("post_rst_held", 0, 0, 0);
        end
        cyc(1'b0); expect_out("post_rst_rel", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
